// File: rtl/isp_bayer_pkg.sv
// isp_bayer_pkg: Bayer phase one-hot codes and CFA order encodings shared by
// the remosaic and demosaic stages.
package isp_bayer_pkg;

    localparam logic [3:0] BAYER_GB = 4'b0001;
    localparam logic [3:0] BAYER_B  = 4'b0010;
    localparam logic [3:0] BAYER_R  = 4'b0100;
    localparam logic [3:0] BAYER_GR = 4'b1000;

    typedef enum logic [1:0] {
        ORDER_RGGB = 2'd0,
        ORDER_GRBG = 2'd1,
        ORDER_GBRG = 2'd2,
        ORDER_BGGR = 2'd3
    } bayer_order_e;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } rgb888_t;

    // Order bit 0 flips the column parity, bit 1 flips the row parity.
    function automatic logic [3:0] bayer_phase(input logic row_odd, input logic col_odd,
                                               input logic [1:0] order);
        logic r, c;
        r = row_odd ^ order[1];
        c = col_odd ^ order[0];
        return r ? (c ? BAYER_B : BAYER_GB) : (c ? BAYER_GR : BAYER_R);
    endfunction

endpackage

// File: rtl/bayer_remosaic_if.sv
// bayer_remosaic_if: RGB pixel input and Bayer raw output bundle.
interface bayer_remosaic_if;

    logic        frame_start;
    logic        in_en;
    logic [7:0]  in_red;
    logic [7:0]  in_green;
    logic [7:0]  in_blue;
    logic [15:0] in_rgb565;
    logic [7:0]  raw_data;
    logic        raw_en;
    logic [3:0]  bayer_state;
    logic        line_end;
    logic        frame_end;
    logic        frame_err;

    modport master (
        output frame_start, in_en, in_red, in_green, in_blue, in_rgb565,
        input  raw_data, raw_en, bayer_state, line_end, frame_end, frame_err
    );

    modport slave (
        input  frame_start, in_en, in_red, in_green, in_blue, in_rgb565,
        output raw_data, raw_en, bayer_state, line_end, frame_end, frame_err
    );

endinterface

// File: rtl/bayer_pos_counter.sv
// bayer_pos_counter: tracks the column/row of each accepted pixel, flags the
// last pixel of a line/frame and detects a frame restart mid-frame.
module bayer_pos_counter #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_start,
    input  logic in_en,
    output logic col_odd,
    output logic row_odd,
    output logic line_last,
    output logic frame_last,
    output logic frame_err
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0] col_q, col_d, col_cur;
    logic [RW-1:0] row_q, row_d, row_cur;
    logic          err_q, err_d;
    logic          at_last_col, at_last_row;

    // frame_start re-bases the pixel accepted in the same cycle to (0,0).
    always_comb begin
        col_cur     = frame_start ? '0 : col_q;
        row_cur     = frame_start ? '0 : row_q;
        at_last_col = col_cur == LAST_COL;
        at_last_row = row_cur == LAST_ROW;
        col_d       = !in_en ? col_cur : at_last_col ? '0 : col_cur + 1'b1;
        row_d       = !(in_en && at_last_col) ? row_cur : at_last_row ? '0 : row_cur + 1'b1;
        err_d       = frame_start && (col_q != '0 || row_q != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
            err_q <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            err_q <= err_d;
        end
    end

    assign col_odd    = col_cur[0];
    assign row_odd    = row_cur[0];
    assign line_last  = in_en && at_last_col;
    assign frame_last = line_last && at_last_row;
    assign frame_err  = err_q;

endmodule

// File: rtl/bayer_remosaic.sv
// bayer_remosaic: re-samples an RGB pixel stream into a single-channel Bayer
// raw stream tagged with the one-hot phase code the demosaic stage expects.
module bayer_remosaic
    import isp_bayer_pkg::*;
#(
    parameter int         IMG_WIDTH   = 640,
    parameter int         IMG_HEIGHT  = 480,
    parameter logic [1:0] BAYER_ORDER = 2'd0,
    parameter bit         USE_RGB565  = 1'b0
) (
    input logic             clk,
    input logic             rst,
    bayer_remosaic_if.slave bus
);

    rgb888_t    pix_in, s1_pix_q, s1_pix_d;
    logic       col_odd, row_odd, line_last, frame_last, pos_err;
    logic       s1_valid_q, s1_valid_d, s1_line_q, s1_line_d, s1_frame_q, s1_frame_d;
    logic [3:0] s1_phase_q, s1_phase_d, state_q, state_d;
    logic [7:0] data_q, data_d, sel;
    logic       en_q, en_d, line_q, line_d, fend_q, fend_d, err_q, err_d;

    bayer_pos_counter #(
        .IMG_WIDTH (IMG_WIDTH),
        .IMG_HEIGHT(IMG_HEIGHT)
    ) u_pos (
        .clk        (clk),
        .rst        (rst),
        .frame_start(bus.frame_start),
        .in_en      (bus.in_en),
        .col_odd    (col_odd),
        .row_odd    (row_odd),
        .line_last  (line_last),
        .frame_last (frame_last),
        .frame_err  (pos_err)
    );

    // Stage 1: expand RGB565 by replicating the top bits into the gap.
    always_comb begin
        pix_in.red   = USE_RGB565 ? {bus.in_rgb565[15:11], bus.in_rgb565[15:13]} : bus.in_red;
        pix_in.green = USE_RGB565 ? {bus.in_rgb565[10:5], bus.in_rgb565[10:9]} : bus.in_green;
        pix_in.blue  = USE_RGB565 ? {bus.in_rgb565[4:0], bus.in_rgb565[4:2]} : bus.in_blue;
        s1_valid_d   = bus.in_en;
        s1_pix_d     = pix_in;
        s1_phase_d   = bayer_phase(row_odd, col_odd, BAYER_ORDER);
        s1_line_d    = line_last;
        s1_frame_d   = frame_last;
    end

    // Stage 2: pick the channel the sensor would have seen; hold phase/data while idle.
    always_comb begin
        sel     = s1_phase_q == BAYER_R ? s1_pix_q.red :
                  s1_phase_q == BAYER_B ? s1_pix_q.blue : s1_pix_q.green;
        data_d  = s1_valid_q ? sel : data_q;
        state_d = s1_valid_q ? s1_phase_q : state_q;
        en_d    = s1_valid_q;
        line_d  = s1_line_q;
        fend_d  = s1_frame_q;
        err_d   = pos_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_pix_q   <= '0;
            s1_phase_q <= '0;
            s1_line_q  <= 1'b0;
            s1_frame_q <= 1'b0;
            data_q     <= '0;
            state_q    <= '0;
            en_q       <= 1'b0;
            line_q     <= 1'b0;
            fend_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_pix_q   <= s1_pix_d;
            s1_phase_q <= s1_phase_d;
            s1_line_q  <= s1_line_d;
            s1_frame_q <= s1_frame_d;
            data_q     <= data_d;
            state_q    <= state_d;
            en_q       <= en_d;
            line_q     <= line_d;
            fend_q     <= fend_d;
            err_q      <= err_d;
        end
    end

    assign bus.raw_data    = data_q;
    assign bus.raw_en      = en_q;
    assign bus.bayer_state = state_q;
    assign bus.line_end    = line_q;
    assign bus.frame_end   = fend_q;
    assign bus.frame_err   = err_q;

endmodule

// File: tb/tb_bayer_remosaic.sv
// tb_bayer_remosaic: four differently configured instances share one stimulus
// stream and are checked every cycle against a position/colour model.
module tb_bayer_remosaic;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        fs = 1'b0, en = 1'b0;
    logic [7:0]  r = '0, g = '0, b = '0;
    logic [15:0] p565 = '0;

    bayer_remosaic_if bus0 ();
    bayer_remosaic_if bus1 ();
    bayer_remosaic_if bus2 ();
    bayer_remosaic_if bus3 ();

    assign bus0.frame_start = fs; assign bus0.in_en = en; assign bus0.in_red = r; assign bus0.in_green = g; assign bus0.in_blue = b; assign bus0.in_rgb565 = p565;
    assign bus1.frame_start = fs; assign bus1.in_en = en; assign bus1.in_red = r; assign bus1.in_green = g; assign bus1.in_blue = b; assign bus1.in_rgb565 = p565;
    assign bus2.frame_start = fs; assign bus2.in_en = en; assign bus2.in_red = r; assign bus2.in_green = g; assign bus2.in_blue = b; assign bus2.in_rgb565 = p565;
    assign bus3.frame_start = fs; assign bus3.in_en = en; assign bus3.in_red = r; assign bus3.in_green = g; assign bus3.in_blue = b; assign bus3.in_rgb565 = p565;

    bayer_remosaic #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .BAYER_ORDER(2'd0), .USE_RGB565(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    bayer_remosaic #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .BAYER_ORDER(2'd3), .USE_RGB565(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    bayer_remosaic #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .BAYER_ORDER(2'd1), .USE_RGB565(1'b1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    bayer_remosaic #(.IMG_WIDTH(640), .IMG_HEIGHT(480), .BAYER_ORDER(2'd2), .USE_RGB565(1'b0)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    localparam int MW   [4] = '{4, 4, 4, 640};
    localparam int MH   [4] = '{2, 2, 2, 480};
    localparam int MO   [4] = '{0, 3, 1, 2};
    localparam int M565 [4] = '{0, 0, 1, 0};

    logic [3:0]      o_en, o_le, o_fe, o_err;
    logic [3:0][7:0] o_data;
    logic [3:0][3:0] o_st;
    assign o_en   = {bus3.raw_en, bus2.raw_en, bus1.raw_en, bus0.raw_en};
    assign o_le   = {bus3.line_end, bus2.line_end, bus1.line_end, bus0.line_end};
    assign o_fe   = {bus3.frame_end, bus2.frame_end, bus1.frame_end, bus0.frame_end};
    assign o_err  = {bus3.frame_err, bus2.frame_err, bus1.frame_err, bus0.frame_err};
    assign o_data = {bus3.raw_data, bus2.raw_data, bus1.raw_data, bus0.raw_data};
    assign o_st   = {bus3.bayer_state, bus2.bayer_state, bus1.bayer_state, bus0.bayer_state};

    int checks = 0, errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Phase from spec table: parity of (position + order offset) per axis.
    function automatic bit [3:0] phase_of(input int row, input int col, input int order);
        int rp, cp;
        rp = (row + order / 2) % 2;
        cp = (col + order % 2) % 2;
        if (rp == 0) return cp == 0 ? 4'b0100 : 4'b1000;
        return cp == 0 ? 4'b0001 : 4'b0010;
    endfunction

    function automatic bit [7:0] expand(input int v, input int n);
        return 8'((v << (8 - n)) | (v >> (2 * n - 8)));
    endfunction

    typedef struct packed {
        bit       v;
        bit [7:0] d;
        bit [3:0] st;
        bit       le, fe, err;
    } exp_t;

    int   mcol [4], mrow [4];
    exp_t pend [4], cur [4];

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                mcol[k] = 0; mrow[k] = 0; pend[k] = '0; cur[k] = '0;
            end else begin
                exp_t e;
                bit [7:0] cr, cg, cb;
                cur[k].v   = pend[k].v;
                cur[k].le  = pend[k].le;
                cur[k].fe  = pend[k].fe;
                cur[k].err = pend[k].err;
                if (pend[k].v) begin
                    cur[k].d  = pend[k].d;
                    cur[k].st = pend[k].st;
                end
                e = '0;
                if (fs) begin
                    e.err = mcol[k] != 0 || mrow[k] != 0;
                    mcol[k] = 0; mrow[k] = 0;
                end
                if (en) begin
                    cr = M565[k] != 0 ? expand(int'(p565[15:11]), 5) : r;
                    cg = M565[k] != 0 ? expand(int'(p565[10:5]), 6) : g;
                    cb = M565[k] != 0 ? expand(int'(p565[4:0]), 5) : b;
                    e.v  = 1'b1;
                    e.st = phase_of(mrow[k], mcol[k], MO[k]);
                    e.d  = e.st == 4'b0100 ? cr : e.st == 4'b0010 ? cb : cg;
                    e.le = mcol[k] == MW[k] - 1;
                    e.fe = e.le && mrow[k] == MH[k] - 1;
                    mcol[k]++;
                    if (mcol[k] == MW[k]) begin
                        mcol[k] = 0;
                        mrow[k] = (mrow[k] + 1) % MH[k];
                    end
                end
                pend[k] = e;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("d%0d_raw_en", k), int'(o_en[k]), int'(cur[k].v));
            chk($sformatf("d%0d_line_end", k), int'(o_le[k]), int'(cur[k].le));
            chk($sformatf("d%0d_frame_end", k), int'(o_fe[k]), int'(cur[k].fe));
            chk($sformatf("d%0d_frame_err", k), int'(o_err[k]), int'(cur[k].err));
            chk($sformatf("d%0d_bayer_state", k), int'(o_st[k]), int'(cur[k].st));
            if (cur[k].v) chk($sformatf("d%0d_raw_data", k), int'(o_data[k]), int'(cur[k].d));
        end
    end

    // Hand-derived first-frame results for the three 4x2 instances.
    localparam bit [7:0] LD [3][8] = '{
        '{8'h10, 8'h20, 8'h10, 8'h20, 8'h20, 8'h30, 8'h20, 8'h30},
        '{8'h30, 8'h20, 8'h30, 8'h20, 8'h20, 8'h10, 8'h20, 8'h10},
        '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h08, 8'h08, 8'h08, 8'h08}};
    localparam bit [3:0] LS [3][8] = '{
        '{4'h4, 4'h8, 4'h4, 4'h8, 4'h1, 4'h2, 4'h1, 4'h2},
        '{4'h2, 4'h1, 4'h2, 4'h1, 4'h8, 4'h4, 4'h8, 4'h4},
        '{4'h8, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2, 4'h1}};
    localparam bit [1:0] LF [8] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd3};

    bit       cap = 1'b0;
    int       cn [3];
    bit [7:0] cd [3][8];
    bit [3:0] cs [3][8];
    bit [1:0] cl [3][8];

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (cap && o_en[k] && cn[k] < 8) begin
                cd[k][cn[k]] = o_data[k];
                cs[k][cn[k]] = o_st[k];
                cl[k][cn[k]] = {o_le[k], o_fe[k]};
                cn[k]++;
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_raw_en", int'(o_en[0]), 0);
        chk("rst_bayer_state", int'(o_st[0]), 0);
        chk("rst_raw_data", int'(o_data[0]), 0);
        chk("rst_frame_err", int'(o_err[0]), 0);
        rst = 1'b0;
        cap = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            fs = i == 0; en = 1'b1; r = 8'h10; g = 8'h20; b = 8'h30;
            p565 = i < 4 ? 16'hF81F : 16'h0841;
            if (i == 1) chk("latency_cycle1", int'(o_en[0]), 0);
            if (i == 2) chk("latency_cycle2", int'(o_en[0]), 1);
        end
        @(negedge clk); fs = 1'b0; en = 1'b0;
        repeat (3) @(negedge clk);
        cap = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("frame1_count_d%0d", k), cn[k], 8);
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("frame1_data_d%0d_px%0d", k, i), int'(cd[k][i]), int'(LD[k][i]));
                chk($sformatf("frame1_state_d%0d_px%0d", k, i), int'(cs[k][i]), int'(LS[k][i]));
            end
        end
        for (int i = 0; i < 8; i++) chk($sformatf("frame1_ends_d1_px%0d", i), int'(cl[1][i]), int'(LF[i]));

        // Mid-frame restart after 5 pixels.
        @(negedge clk); fs = 1'b1; en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); fs = 1'b0; en = 1'b1; r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
        end
        @(negedge clk); fs = 1'b1; en = 1'b0;
        @(negedge clk); fs = 1'b0;
        chk("restart_err_early", int'(o_err[0]), 0);
        @(negedge clk); en = 1'b1; r = 8'h55; g = 8'h66; b = 8'h77;
        chk("restart_err_d0", int'(o_err[0]), 1);
        chk("restart_err_d3", int'(o_err[3]), 1);
        @(negedge clk); en = 1'b0;
        chk("restart_err_width", int'(o_err[0]), 0);
        @(negedge clk);
        chk("restart_px_state_d0", int'(o_st[0]), 4);
        chk("restart_px_data_d0", int'(o_data[0]), 8'h55);
        chk("restart_px_state_d3", int'(o_st[3]), 1);
        chk("restart_px_data_d3", int'(o_data[3]), 8'h66);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); en = 1'b1; r = 8'($urandom);
        end
        @(negedge clk); fs = 1'b1; en = 1'b1; r = 8'h9A; g = 8'h01; b = 8'h02;
        @(negedge clk); fs = 1'b0; en = 1'b0;
        @(negedge clk);
        chk("coincident_state", int'(o_st[0]), 4);
        chk("coincident_data", int'(o_data[0]), 8'h9A);
        chk("coincident_err", int'(o_err[0]), 1);

        // Gapped valid: raw_en echoes the in_en pattern two cycles later.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); en = i < 4 && i % 2 == 0; r = 8'($urandom);
            if (i >= 2) chk($sformatf("gap_raw_en_%0d", i), int'(o_en[0]), int'(i % 2 == 0));
        end

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst  = $urandom_range(0, 499) == 0;
            fs   = $urandom_range(0, 149) == 0;
            en   = $urandom_range(0, 9) < 7;
            r    = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
            p565 = 16'($urandom);
        end

        // Reset with two pixels in flight.
        @(negedge clk); rst = 1'b0; fs = 1'b0; en = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk); en = 1'b1; r = 8'h11; g = 8'h22; b = 8'h33;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; en = 1'b1; r = 8'h44; g = 8'h45; b = 8'h46;
        chk("flush_raw_en", int'(o_en[0]), 0);
        chk("flush_bayer_state", int'(o_st[0]), 0);
        chk("flush_raw_data", int'(o_data[0]), 0);
        chk("flush_line_end", int'(o_le[0]), 0);
        @(negedge clk); en = 1'b0;
        chk("flush_no_raw_en", int'(o_en[0]), 0);
        @(negedge clk);
        chk("post_rst_raw_en", int'(o_en[0]), 1);
        chk("post_rst_state", int'(o_st[0]), 4);
        chk("post_rst_data", int'(o_data[0]), 8'h44);
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bayer_remosaic.md
# bayer_remosaic

Converts a streaming RGB pixel feed back into a single-channel 8-bit Bayer raw stream, the inverse direction of the ISP demosaic stage. It samples the colour component that a sensor of the configured CFA order would have captured at each pixel position and emits it together with the one-hot Bayer phase code the demosaic stage consumes. It sits between the RGB test-pattern/loopback path and the raw line buffers, so processed or synthetic RGB frames can be re-injected into the raw ISP chain.

## Interface
- IMG_WIDTH, 640, active pixels per line (≥2, even)
- IMG_HEIGHT, 480, active lines per frame (≥2, even)
- BAYER_ORDER, 2'd0, CFA order of pixel (0,0): 0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR
- USE_RGB565, 0, 1: take colour from in_rgb565; 0: take in_red/in_green/in_blue
- clk  in  1  pixel clock
- rst  in  1  reset; synchronous, active-high (one clock; polarity and synchronicity fixed)
- frame_start  in  1  single-cycle start-of-frame pulse; clears position counters
- in_en  in  1  input pixel valid
- in_red, in_green, in_blue  in  8 each  RGB888 pixel
- in_rgb565  in  16  {R[4:0],G[5:0],B[4:0]} pixel
- raw_data  out  8  Bayer sample
- raw_en  out  1  raw_data valid
- bayer_state  out  4  one-hot phase: 4'b0001 Gb, 4'b0010 B, 4'b0100 R, 4'b1000 Gr
- line_end  out  1  with raw_en on last pixel of a line
- frame_end  out  1  with raw_en on last pixel of a frame
- frame_err  out  1  single-cycle pulse: frame_start arrived mid-frame

## Operation
- No backpressure; in_en may have arbitrary gaps; one pixel accepted per in_en cycle.
- Position: col (0..IMG_WIDTH-1), row (0..IMG_HEIGHT-1). Each accepted pixel advances col; col wraps at IMG_WIDTH-1 and row increments; row wraps at IMG_HEIGHT-1 (frame_end). After a full frame, counters are at (0,0) without needing frame_start.
- Phase: c = col[0] ^ BAYER_ORDER[0], r = row[0] ^ BAYER_ORDER[1]; (r,c) = (0,0) R, (0,1) Gr, (1,0) Gb, (1,1) B.
- Sample: R phase → red, B phase → blue, Gr/Gb → green.
- RGB565 expansion by bit replication: R8 = {R5,R5[4:2]}, G8 = {G6,G6[5:4]}, B8 = {B5,B5[4:2]}.
- frame_start: counters forced to (0,0). If in_en is high the same cycle, that pixel is (0,0). If counters were not at (0,0) when frame_start arrives, frame_err pulses (aligned with frame_start + 2 cycles). Pixels already in the pipeline complete unchanged.
- Reset mid-frame: pipeline flushed, counters (0,0), no outputs for in-flight pixels.

## Timing
- Latency: pixel accepted at cycle N appears with raw_en at N+2 (stage 1: capture colour, expand, compute phase/flags; stage 2: select and register outputs).
- raw_en, bayer_state, line_end, frame_end, raw_data all registered, mutually aligned; bayer_state holds last value when raw_en low.
- Reset values: raw_data 8'h00, raw_en 0, bayer_state 4'b0000, line_end 0, frame_end 0, frame_err 0, col 0, row 0.
- frame_end implies line_end in the same cycle.
- Throughput: one pixel per clock sustained.

## Structure
- Shared package isp_bayer_pkg: one-hot phase constants (BAYER_GB/B/R/GR) matching demosaic encoding; BAYER_ORDER encodings; function mapping (row parity, col parity, order) → one-hot phase. Demosaic-side code imports the same constants.
- Sub-module bayer_pos_counter: col/row counters, wrap logic, line_end/frame_end/frame_err generation, frame_start handling. Top holds colour expansion and the two-stage pipeline.

## Test plan
- BAYER_ORDER=0, 4x2 frame, constant RGB (0x10,0x20,0x30), continuous in_en → raw_data 10,20,10,20 / 20,30,20,30; bayer_state R,Gr,R,Gr / Gb,B,Gb,B; raw_en 2 cycles after first in_en.
- Same stream, BAYER_ORDER=3 → first line 30,20,30,20 with B,Gb; line_end on pixels 3 and 7; frame_end only on pixel 7.
- USE_RGB565=1, in_rgb565=16'hF81F → R phase 0xFF, G phase 0x00, B phase 0xFF; 16'h0841 → R 0x08, G 0x08, B 0x08.
- in_en toggled 1-0-1-0 → raw_en pattern mirrors input delayed 2 cycles; col advances only on valid pixels.
- frame_start after 5 pixels of 640x480 → frame_err pulse; next pixel emitted as (0,0) R phase; frame_start coincident with in_en → that pixel is (0,0).
- rst asserted with 2 pixels in flight → all outputs 0 next cycle, no raw_en for flushed pixels; first pixel after release is (0,0).
